// File: rtl/pipe_stage_hs_pkg.sv
// Shared constants for pipeline stage registers: the NOP instruction encoding
// and the standard concatenated payload widths carried between stages.
package pipe_stage_hs_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  localparam int unsigned IF_ID_W  = INST_W + ADDR_W;
  localparam int unsigned ID_EX_W  = INST_W + ADDR_W + 2 * 32;
  localparam int unsigned EX_MEM_W = INST_W + ADDR_W + 32;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single-entry skid slot: catches the beat accepted while the main register is
// full and stalled, and hands it back when the main register drains.
module pipe_skid_buf
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned       DATA_W  = IF_ID_W,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = NOP_VAL;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      // Park a defined value so an empty slot never carries stale data.
      valid_d = 1'b0;
      data_d  = NOP_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register with hold (freeze), flush (bubble),
// an optional skid entry for registered in_ready, and a saturating stall counter.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned       DATA_W  = IF_ID_W,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter int unsigned       SKID    = 0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_push, skid_pop;
  logic              in_fire, out_fire;

  // Flush always accepts (and drops) the incoming beat; hold blocks it.
  always_comb begin
    if (flush_i) begin
      in_ready_o = 1'b1;
    end else if (hold_i) begin
      in_ready_o = 1'b0;
    end else if (SKID != 0) begin
      in_ready_o = !skid_valid;
    end else begin
      in_ready_o = !valid_q || out_ready_i;
    end
  end

  // A stage being killed or frozen must not hand its payload downstream.
  assign out_valid_o = valid_q && !hold_i && !flush_i;
  assign out_data_o  = valid_q ? data_q : NOP_VAL;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = NOP_VAL;
    end else if (hold_i) begin
      valid_d = valid_q;
    end else if (skid_valid) begin
      // in_ready is low while the skid is full, so only a drain can happen.
      if (out_fire) begin
        data_d   = skid_data;
        skid_pop = 1'b1;
      end
    end else if (in_fire) begin
      if (!valid_q || out_fire) begin
        valid_d = 1'b1;
        data_d  = in_data_i;
      end else begin
        skid_push = 1'b1;
      end
    end else if (out_fire) begin
      valid_d = 1'b0;
      data_d  = NOP_VAL;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid_o && !out_ready_i && !(&stall_q)) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VAL;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(
      .DATA_W  (DATA_W),
      .NOP_VAL (NOP_VAL)
    ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .push_i  (skid_push),
      .pop_i   (skid_pop),
      .data_i  (in_data_i),
      .valid_o (skid_valid),
      .data_o  (skid_data)
    );
  end else begin : g_no_skid
    logic unused_skid;
    assign skid_valid  = 1'b0;
    assign skid_data   = NOP_VAL;
    assign unused_skid = skid_push | skid_pop;
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: a SKID=0 stage (4-bit stall counter) and a
// SKID=1 stage share stimulus; per-stage scoreboards check order and loss.
module tb_pipe_stage_hs;

  localparam int unsigned       DW  = 16;
  localparam logic [DW-1:0]     NOP = 16'h0013;

  logic          clk = 1'b0;
  logic          rst, hold, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;

  logic          in_ready0, out_valid0;
  logic [DW-1:0] out_data0;
  logic [3:0]    stall0;
  logic          in_ready1, out_valid1;
  logic [DW-1:0] out_data1;
  logic [15:0]   stall1;

  int total = 0;
  int bad   = 0;
  int dlv1  = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(0), .CNT_W(4)) dut_s0 (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready0),
    .in_data_i   (in_data),
    .out_valid_o (out_valid0),
    .out_ready_i (out_ready),
    .out_data_o  (out_data0),
    .stall_cnt_o (stall0)
  );

  pipe_stage_hs #(.DATA_W(DW), .NOP_VAL(NOP), .SKID(1), .CNT_W(16)) dut_s1 (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready1),
    .in_data_i   (in_data),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready),
    .out_data_o  (out_data1),
    .stall_cnt_o (stall1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard sampling at negedge, then return just after posedge.
  task automatic cyc();
    logic [DW-1:0] e;
    @(negedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out_valid0 && out_ready) begin
        chk("sb0_pending", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("sb0_data", out_data0, e);
        end
      end
      if (out_valid1 && out_ready) begin
        dlv1++;
        chk("sb1_pending", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("sb1_data", out_data1, e);
        end
      end
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (in_valid && in_ready0) q0.push_back(in_data);
        if (in_valid && in_ready1) q1.push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0;
    cyc(); cyc();
    chk("rst_valid0", out_valid0, 0);
    chk("rst_data0",  out_data0,  NOP);
    chk("rst_ready0", in_ready0,  1);
    chk("rst_stall0", stall0,     0);
    chk("rst_valid1", out_valid1, 0);
    chk("rst_data1",  out_data1,  NOP);
    chk("rst_ready1", in_ready1,  1);
    chk("rst_stall1", stall1,     0);
    rst = 1'b0;
    cyc();

    // Streaming at full rate.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      cyc();
      chk("str_valid0", out_valid0, 1);
      chk("str_data0",  out_data0,  i);
      chk("str_valid1", out_valid1, 1);
      chk("str_data1",  out_data1,  i);
    end
    in_valid = 1'b0;
    cyc();
    chk("str_empty0", out_valid0, 0);
    chk("str_nop0",   out_data0,  NOP);
    chk("str_empty1", out_valid1, 0);
    chk("str_nop1",   out_data1,  NOP);

    // Backpressure into the skid entry.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    cyc();
    chk("bp_ready_a", in_ready1, 1);
    chk("bp_stall_a", stall1,    0);
    chk("bp_data_a",  out_data1, 16'h000A);
    in_data = 16'h000B;
    cyc();
    chk("bp_ready_b",  in_ready1,  0);
    chk("bp_stall_b",  stall1,     1);
    chk("bp_valid_b",  out_valid1, 1);
    chk("bp_ready0_b", in_ready0,  0);
    in_valid = 1'b0;
    cyc();
    chk("bp_stall_2", stall1, 2);
    cyc();
    chk("bp_stall_3", stall1, 3);
    out_ready = 1'b1;
    settle();
    chk("bp_out_a", out_data1, 16'h000A);
    cyc();
    chk("bp_out_b",    out_data1, 16'h000B);
    chk("bp_reopen",   in_ready1, 1);
    chk("bp_stall_hd", stall1,    3);
    cyc();
    chk("bp_drained", out_valid1, 0);
    chk("bp_q1_empty", q1.size(), 0);

    // Flush with main=5, skid=6 and a 0x7 beat in the flush cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0005;
    cyc();
    in_data = 16'h0006;
    cyc();
    chk("fl_skid_full", in_ready1, 0);
    chk("fl_main5",     out_data1, 16'h0005);
    flush   = 1'b1;
    in_data = 16'h0007;
    settle();
    chk("fl_ready1", in_ready1, 1);
    chk("fl_ready0", in_ready0, 1);
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    settle();
    chk("fl_valid1",  out_valid1, 0);
    chk("fl_nop1",    out_data1,  NOP);
    chk("fl_skid_mt", in_ready1,  1);
    chk("fl_valid0",  out_valid0, 0);
    chk("fl_nop0",    out_data0,  NOP);
    chk("fl_stall_kept", stall1 >= 16'd4, 1);
    out_ready = 1'b1;
    cyc();
    chk("fl_no_refill", out_valid1, 0);
    chk("fl_q1_empty",  q1.size(),  0);

    // Hold: 0x9 frozen for 3 cycles, then delivered exactly once.
    rst = 1'b1;
    cyc(); cyc();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0009;
    cyc();
    hold     = 1'b1;
    in_valid = 1'b0;
    settle();
    chk("hd_valid1", out_valid1, 0);
    chk("hd_ready1", in_ready1,  0);
    chk("hd_valid0", out_valid0, 0);
    chk("hd_ready0", in_ready0,  0);
    dlv1 = 0;
    repeat (3) begin
      cyc();
      chk("hd_frz_valid", out_valid1, 0);
      chk("hd_frz_ready", in_ready1,  0);
      chk("hd_frz_data",  out_data1,  16'h0009);
      chk("hd_frz_stall", stall1,     0);
    end
    hold = 1'b0;
    settle();
    chk("hd_back_valid", out_valid1, 1);
    chk("hd_back_data",  out_data1,  16'h0009);
    cyc();
    chk("hd_gone", out_valid1, 0);
    chk("hd_once", dlv1,       1);
    cyc();
    chk("hd_once2", dlv1, 1);

    // Hold and flush together: flush wins.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000C;
    cyc();
    in_valid = 1'b0;
    hold     = 1'b1;
    flush    = 1'b1;
    settle();
    chk("hf_ready", in_ready1, 1);
    cyc();
    hold  = 1'b0;
    flush = 1'b0;
    settle();
    chk("hf_valid1", out_valid1, 0);
    chk("hf_nop1",   out_data1,  NOP);
    chk("hf_valid0", out_valid0, 0);

    // Stall counter saturation on the 4-bit counter.
    rst = 1'b1;
    cyc(); cyc();
    rst       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    cyc();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk("sat_cnt0", stall0, (i > 15) ? 15 : i);
    end
    chk("sat_cnt1", stall1, 20);
    out_ready = 1'b1;
    cyc();
    cyc();
    chk("end_q0", q0.size(),  0);
    chk("end_q1", q1.size(),  0);
    chk("end_v0", out_valid0, 0);
    chk("end_v1", out_valid1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
